// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
// Program-counter / next-PC stage for the single-cycle core. Every cycle it
// presents the fetch address and resolves the next PC. The priority order is
// halt, return, call, jump, taken branch, then sequential. It drives the
// return-address stack directly and tracks call depth, so overflow and
// underflow end in an ERROR state instead of corrupting the stack.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   start                   begin/restart at START_ADDR (IDLE, HALTED, ERROR)
//   stall                   freeze all state for this cycle
//   halt/ret/call/jump      decoded control-flow flags
//   branch/taken            conditional branch and its resolved condition
//   target_in               jump/branch/call target
//   ret_target              combinational top-of-stack from the RAS
//   prog_ctr                registered fetch address
//   ras_addr                address of the calling instruction (== prog_ctr)
//   ras_call/ras_ret        combinational push/pop strobes to the RAS
//   done                    high in HALTED and ERROR
//   stack_err               sticky overflow/underflow flag
//   instr_count             saturating count of retired RUN cycles
module fetch_pc_sequencer #(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 8,
  parameter int START_ADDR  = 0,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          ret,
  input  logic          call,
  input  logic          jump,
  input  logic          branch,
  input  logic          taken,
  input  logic [D-1:0]  target_in,
  input  logic [D-1:0]  ret_target,
  output logic [D-1:0]  prog_ctr,
  output logic [D-1:0]  ras_addr,
  output logic          ras_call,
  output logic          ras_ret,
  output logic          done,
  output logic          stack_err,
  output logic [CW-1:0] instr_count
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [D-1:0]  pc_nxt;
  logic [DW-1:0] depth, depth_nxt;
  logic          done_nxt, err_nxt;
  logic [CW-1:0] count_nxt;
  logic          restart;

  // The caller's own address goes to the RAS; the stack adds one when pushing.
  assign ras_addr = prog_ctr;

  // start is honoured in every state except RUN.
  assign restart = start && (state != ST_RUN);

  // Next-state logic. While reset is asserted the state is forced to IDLE,
  // which also keeps both RAS strobes low.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    depth_nxt = depth;
    done_nxt  = done;
    err_nxt   = stack_err;
    count_nxt = instr_count;
    ras_call  = 1'b0;
    ras_ret   = 1'b0;

    if (restart) begin
      state_nxt = ST_RUN;
      pc_nxt    = D'(START_ADDR);
      depth_nxt = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      count_nxt = '0;
    end else if (state == ST_RUN && !stall) begin
      if (instr_count != {CW{1'b1}})
        count_nxt = instr_count + CW'(1);

      if (halt) begin
        state_nxt = ST_HALTED;
        done_nxt  = 1'b1;
      end else if (ret) begin
        if (depth != '0) begin
          ras_ret   = 1'b1;
          pc_nxt    = ret_target;
          depth_nxt = depth - DW'(1);
        end else begin
          // Underflow: no pop is issued, so the stack is left untouched.
          state_nxt = ST_ERROR;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end else if (call) begin
        if (depth < DW'(STACK_DEPTH)) begin
          ras_call  = 1'b1;
          pc_nxt    = target_in;
          depth_nxt = depth + DW'(1);
        end else begin
          // Overflow: no push is issued, so no entry gets overwritten.
          state_nxt = ST_ERROR;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end else if (jump || (branch && taken)) begin
        pc_nxt = target_in;
      end else begin
        pc_nxt = prog_ctr + D'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prog_ctr    <= D'(START_ADDR);
      depth       <= '0;
      done        <= 1'b0;
      stack_err   <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      prog_ctr    <= pc_nxt;
      depth       <= depth_nxt;
      done        <= done_nxt;
      stack_err   <= err_nxt;
      instr_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed testbench for fetch_pc_sequencer. Inputs are driven 1ns after a
// rising edge. Strobes are sampled 1ns after driving. Registers are sampled
// 1ns after the next rising edge.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, stall, halt, ret, call, jump, branch, taken;
  logic [11:0] target_in, ret_target;
  logic [11:0] prog_ctr, ras_addr;
  logic        ras_call, ras_ret, done, stack_err;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  fetch_pc_sequencer #(
    .D(12), .STACK_DEPTH(8), .START_ADDR(0), .CW(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .halt(halt), .ret(ret), .call(call), .jump(jump), .branch(branch),
    .taken(taken), .target_in(target_in), .ret_target(ret_target),
    .prog_ctr(prog_ctr), .ras_addr(ras_addr), .ras_call(ras_call),
    .ras_ret(ras_ret), .done(done), .stack_err(stack_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    stall = 0; halt = 0; ret = 0; call = 0; jump = 0; branch = 0; taken = 0;
    start = 0; target_in = 12'h000; ret_target = 12'h000;
  endtask

  // Reset pulse between edges, then one start cycle: RUN at PC 0, depth 0.
  task automatic restart();
    reset_n = 0;
    #2;
    reset_n = 1;
    clear_flags();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_flags();
    call = 1;
    target_in = 12'h0AA;
    repeat (2) tick();
    #1;
    checks++; if (prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", prog_ctr, 12'h000); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", stack_err); end
    checks++; if (instr_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", instr_count); end
    checks++; if (ras_call !== 1'b0 || ras_ret !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes: got call=%b ret=%b expected 0/0", ras_call, ras_ret); end
    reset_n = 1;
    // IDLE without start: the PC holds and no strobe fires.
    repeat (2) tick();
    checks++; if (prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL idle_hold_pc: got %h expected %h", prog_ctr, 12'h000); end
    checks++; if (ras_call !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_call: got %b expected 0", ras_call); end
    clear_flags();
  endtask

  task automatic test_sequential();
    start = 1;
    tick();
    start = 0;
    checks++; if (prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL seq_first_pc: got %h expected %h", prog_ctr, 12'h000); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (prog_ctr !== 12'(i)) begin failures++; $display("[TB] FAIL seq_pc_%0d: got %h expected %h", i, prog_ctr, 12'(i)); end
    end
    checks++; if (instr_count !== 16'd5) begin failures++; $display("[TB] FAIL seq_count: got %0d expected 5", instr_count); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL seq_done: got %b expected 0", done); end
  endtask

  task automatic test_call_return();
    restart();
    repeat (3) tick();
    call = 1; target_in = 12'h040;
    #1;
    checks++; if (ras_call !== 1'b1 || ras_ret !== 1'b0) begin failures++; $display("[TB] FAIL call_strobe: got call=%b ret=%b expected 1/0", ras_call, ras_ret); end
    checks++; if (ras_addr !== 12'h003) begin failures++; $display("[TB] FAIL call_ras_addr: got %h expected %h", ras_addr, 12'h003); end
    tick();
    clear_flags();
    checks++; if (prog_ctr !== 12'h040) begin failures++; $display("[TB] FAIL call_target: got %h expected %h", prog_ctr, 12'h040); end
    tick();
    ret = 1; ret_target = 12'h004;
    #1;
    checks++; if (ras_ret !== 1'b1 || ras_call !== 1'b0) begin failures++; $display("[TB] FAIL ret_strobe: got ret=%b call=%b expected 1/0", ras_ret, ras_call); end
    tick();
    checks++; if (prog_ctr !== 12'h004) begin failures++; $display("[TB] FAIL ret_target: got %h expected %h", prog_ctr, 12'h004); end
    // Depth is back to 0, so another return underflows.
    #1;
    checks++; if (ras_ret !== 1'b0) begin failures++; $display("[TB] FAIL underflow_strobe: got %b expected 0", ras_ret); end
    tick();
    clear_flags();
    checks++; if (done !== 1'b1 || stack_err !== 1'b1) begin failures++; $display("[TB] FAIL underflow_flags: got done=%b err=%b expected 1/1", done, stack_err); end
    checks++; if (prog_ctr !== 12'h004) begin failures++; $display("[TB] FAIL underflow_pc: got %h expected %h", prog_ctr, 12'h004); end
    checks++; if (instr_count !== 16'd7) begin failures++; $display("[TB] FAIL underflow_count: got %0d expected 7", instr_count); end
    tick();
    checks++; if (prog_ctr !== 12'h004 || instr_count !== 16'd7) begin failures++; $display("[TB] FAIL error_hold: got pc=%h count=%0d expected 004/7", prog_ctr, instr_count); end
  endtask

  task automatic test_overflow();
    restart();
    for (int i = 0; i < 8; i++) begin
      call = 1; target_in = 12'h100 + 12'(i * 16);
      #1;
      checks++; if (ras_call !== 1'b1) begin failures++; $display("[TB] FAIL nest_call_%0d: got %b expected 1", i, ras_call); end
      tick();
      checks++; if (prog_ctr !== 12'h100 + 12'(i * 16)) begin failures++; $display("[TB] FAIL nest_pc_%0d: got %h expected %h", i, prog_ctr, 12'h100 + 12'(i * 16)); end
    end
    target_in = 12'h200;
    #1;
    checks++; if (ras_call !== 1'b0) begin failures++; $display("[TB] FAIL overflow_strobe: got %b expected 0", ras_call); end
    tick();
    checks++; if (prog_ctr !== 12'h170) begin failures++; $display("[TB] FAIL overflow_pc: got %h expected %h", prog_ctr, 12'h170); end
    checks++; if (done !== 1'b1 || stack_err !== 1'b1) begin failures++; $display("[TB] FAIL overflow_flags: got done=%b err=%b expected 1/1", done, stack_err); end
    #1;
    checks++; if (ras_call !== 1'b0) begin failures++; $display("[TB] FAIL error_call_ignored: got %b expected 0", ras_call); end
    clear_flags();
    start = 1;
    tick();
    start = 0;
    checks++; if (stack_err !== 1'b0 || done !== 1'b0 || prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL error_restart: got err=%b done=%b pc=%h expected 0/0/000", stack_err, done, prog_ctr); end
  endtask

  task automatic test_priority_stall();
    restart();
    call = 1; target_in = 12'h050;
    tick();
    call = 1; ret = 1; jump = 1; target_in = 12'h060; ret_target = 12'h123;
    #1;
    checks++; if (ras_ret !== 1'b1 || ras_call !== 1'b0) begin failures++; $display("[TB] FAIL prio_strobes: got ret=%b call=%b expected 1/0", ras_ret, ras_call); end
    tick();
    clear_flags();
    checks++; if (prog_ctr !== 12'h123) begin failures++; $display("[TB] FAIL prio_pc: got %h expected %h", prog_ctr, 12'h123); end
    branch = 1; taken = 0; target_in = 12'h300;
    tick();
    checks++; if (prog_ctr !== 12'h124) begin failures++; $display("[TB] FAIL branch_not_taken: got %h expected %h", prog_ctr, 12'h124); end
    taken = 1;
    tick();
    checks++; if (prog_ctr !== 12'h300) begin failures++; $display("[TB] FAIL branch_taken: got %h expected %h", prog_ctr, 12'h300); end
    clear_flags();
    jump = 1; target_in = 12'h2AB;
    tick();
    checks++; if (prog_ctr !== 12'h2AB) begin failures++; $display("[TB] FAIL jump_pc: got %h expected %h", prog_ctr, 12'h2AB); end
    clear_flags();
    stall = 1; call = 1; target_in = 12'h777;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ras_call !== 1'b0 || ras_ret !== 1'b0) begin failures++; $display("[TB] FAIL stall_strobes_%0d: got call=%b ret=%b expected 0/0", i, ras_call, ras_ret); end
      tick();
      checks++; if (prog_ctr !== 12'h2AB || instr_count !== 16'd5) begin failures++; $display("[TB] FAIL stall_hold_%0d: got pc=%h count=%0d expected 2ab/5", i, prog_ctr, instr_count); end
    end
    clear_flags();
    tick();
    checks++; if (prog_ctr !== 12'h2AC || instr_count !== 16'd6) begin failures++; $display("[TB] FAIL after_stall: got pc=%h count=%0d expected 2ac/6", prog_ctr, instr_count); end
  endtask

  task automatic test_halt_restart();
    restart();
    repeat (7) tick();
    halt = 1;
    tick();
    clear_flags();
    checks++; if (done !== 1'b1 || prog_ctr !== 12'h007 || instr_count !== 16'd8) begin failures++; $display("[TB] FAIL halt: got done=%b pc=%h count=%0d expected 1/007/8", done, prog_ctr, instr_count); end
    jump = 1; call = 1; target_in = 12'h055;
    #1;
    checks++; if (ras_call !== 1'b0) begin failures++; $display("[TB] FAIL halted_strobe: got %b expected 0", ras_call); end
    tick();
    checks++; if (prog_ctr !== 12'h007 || done !== 1'b1 || instr_count !== 16'd8) begin failures++; $display("[TB] FAIL halted_hold: got pc=%h done=%b count=%0d expected 007/1/8", prog_ctr, done, instr_count); end
    clear_flags();
    start = 1;
    tick();
    start = 0;
    checks++; if (prog_ctr !== 12'h000 || instr_count !== 16'd0 || done !== 1'b0) begin failures++; $display("[TB] FAIL halt_restart: got pc=%h count=%0d done=%b expected 000/0/0", prog_ctr, instr_count, done); end
    tick();
    checks++; if (prog_ctr !== 12'h001) begin failures++; $display("[TB] FAIL restart_run: got %h expected %h", prog_ctr, 12'h001); end
    jump = 1; target_in = 12'hFFF;
    tick();
    clear_flags();
    checks++; if (prog_ctr !== 12'hFFF) begin failures++; $display("[TB] FAIL wrap_jump: got %h expected %h", prog_ctr, 12'hFFF); end
    tick();
    checks++; if (prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL wrap_pc: got %h expected %h", prog_ctr, 12'h000); end
  endtask

  task automatic test_async_reset();
    restart();
    call = 1; target_in = 12'h010; tick();
    target_in = 12'h020; tick();
    target_in = 12'h022; tick();
    clear_flags();
    repeat (3) tick();
    checks++; if (prog_ctr !== 12'h025 || instr_count !== 16'd6) begin failures++; $display("[TB] FAIL pre_reset: got pc=%h count=%0d expected 025/6", prog_ctr, instr_count); end
    call = 1;
    #2;
    reset_n = 0;
    #1;
    checks++; if (prog_ctr !== 12'h000 || instr_count !== 16'd0 || done !== 1'b0 || stack_err !== 1'b0) begin failures++; $display("[TB] FAIL async_reset: got pc=%h count=%0d done=%b err=%b expected 000/0/0/0", prog_ctr, instr_count, done, stack_err); end
    checks++; if (ras_call !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_strobe: got %b expected 0", ras_call); end
    #1;
    reset_n = 1;
    clear_flags();
    tick();
    checks++; if (prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL post_reset_idle: got %h expected %h", prog_ctr, 12'h000); end
    // Depth was cleared as well: the first return after start underflows.
    start = 1;
    tick();
    start = 0;
    ret = 1; ret_target = 12'h0F0;
    #1;
    checks++; if (ras_ret !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_depth: got %b expected 0", ras_ret); end
    tick();
    clear_flags();
    checks++; if (stack_err !== 1'b1 || prog_ctr !== 12'h000) begin failures++; $display("[TB] FAIL post_reset_underflow: got err=%b pc=%h expected 1/000", stack_err, prog_ctr); end
  endtask

  initial begin
    $display("[TB] fetch_pc_sequencer directed test");
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow();
    test_priority_stall();
    test_halt_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
